mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Backing-memory responder at the bottom of the L1/L2 hierarchy. It services L2 fill reads and write-back writes over a valid/ready request channel and a valid/ready response channel.
- Each accepted request is queued, held for a fixed access latency, then answered in order.
- Maintains saturating read, write and bad-op counters for the bench's miss-traffic statistics, in the same style as the cache's L1/L2 counters.

Parameters:
- ADDR_W, 32, request/response address width
- LATENCY, 4, access latency in cycles from dequeue to response; legal range 1..255
- DEPTH, 4, request queue entries; power of two, >= 2
- CNT_W, 12, statistics counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  queue can accept a request
- req_addr  in  ADDR_W  block address
- req_op  in  8  ASCII op code: 8'h72 'r' = read, 8'h77 'w' = write
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_addr  out  ADDR_W  address of the answered request
- rsp_op  out  8  op of the answered request
- rsp_err  out  1  answered request had an illegal op
- mem_reads  out  CNT_W  completed read responses
- mem_writes  out  CNT_W  completed write responses
- bad_ops  out  CNT_W  completed illegal-op responses
- busy  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: when reset is sampled high at an edge, the block flushes the queue and forces the FSM to IDLE.
  - Reset values: rsp_valid, rsp_err, busy = 0; rsp_addr, rsp_op = 0; all three counters = 0.
  - Reset takes priority over every other event, including mid-WAIT or mid-RESP. In-flight requests are dropped without a response.
- Request channel:
  - Transfer occurs at an edge where req_valid && req_ready.
  - req_ready = !full, purely from occupancy. A pop in the same cycle does not raise ready while full.
  - req_ready is independent of req_valid.
- Queue: FIFO of {addr, op}, DEPTH entries, wrap-around pointers, in-order service.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if the queue is non-empty, pop the head into the hold register, load cnt = LATENCY-1 and go to WAIT.
  - WAIT: if cnt == 0, go to RESP and set rsp_valid = 1; otherwise decrement cnt.
  - RESP: rsp_valid, rsp_addr, rsp_op and rsp_err are held stable until rsp_ready. On the handshake edge:
    - update the counters;
    - if the queue is non-empty, pop directly into WAIT with cnt = LATENCY-1 (no IDLE bubble);
    - otherwise go to IDLE and drop rsp_valid.
- Latency:
  - A request accepted at edge t into an empty, idle block gives rsp_valid high after edge t+1+LATENCY.
  - A same-cycle push and pop on an empty queue is not bypassed; the request is popped on the following edge.
- Op decode:
  - 'r' increments mem_reads on completion.
  - 'w' increments mem_writes on completion.
  - Any other value is still queued and answered with rsp_err = 1, and increments bad_ops only.
  - rsp_err is combinationally derived from the held op; it is valid only while rsp_valid.
- Counters:
  - Increment only on the response handshake edge.
  - Saturate at all-ones; no wrap.

Decomposition:
- cache_pkg holds:
  - OP_READ = 8'h72, OP_WRITE = 8'h77;
  - resp_state_t enum {IDLE, WAIT, RESP};
  - a mem_req_t struct {addr, op}.
- Sub-module mem_req_fifo (parameters DEPTH and width) provides push/pop/full/empty/count.
- The latency FSM, decode and counters stay in mem_responder.

Test Plan:
1. Single read: LATENCY=4, req 32'h0000_1A40 'r' accepted at edge 0, rsp_ready=1 → rsp_valid rises after edge 5 with rsp_addr=32'h0000_1A40 and rsp_err=0; mem_reads=1 after the handshake; busy=0 after edge 6.
2. Queue full and ordering: push 5 requests back-to-back (3 'r', 2 'w') with rsp_ready=0.
   - req_ready falls after the 4th queued entry (head popped at edge 1, so 5 are accepted in total).
   - Release rsp_ready → responses appear in issue order, spaced LATENCY+1 cycles apart.
   - Final mem_reads=3, mem_writes=2.
3. Backpressure stability: response pending with rsp_ready low for 10 cycles → rsp_valid/addr/op/err unchanged every cycle; counters unchanged until the handshake edge.
4. Illegal op: req_op=8'h78 → response with rsp_err=1; bad_ops=1; mem_reads and mem_writes stay 0.
5. Reset mid-operation: assert reset during WAIT with 2 entries queued → next cycle rsp_valid=0, busy=0, req_ready=1, counters 0; no response ever appears for the flushed requests.
6. Saturation: CNT_W=2, 5 completed reads → mem_reads=3 and stays 3.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the backing-memory responder: op codes, FSM states and op decode.
package mem_responder_pkg;

    localparam logic [7:0] OP_READ  = 8'h72;
    localparam logic [7:0] OP_WRITE = 8'h77;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } resp_state_t;

    typedef enum logic [1:0] {
        OpRead,
        OpWrite,
        OpBad
    } op_class_t;

    function automatic op_class_t classify_op(input logic [7:0] op);
        if (op == OP_READ) begin
            return OpRead;
        end else if (op == OP_WRITE) begin
            return OpWrite;
        end
        return OpBad;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel bundle between the L2 fill/write-back path and the memory responder.
interface mem_responder_if #(
    parameter int unsigned ADDR_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [7:0]        rsp_op;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_addr,
        output req_op,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_addr,
        input  rsp_op,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_op,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_addr,
        output rsp_op,
        output rsp_err
    );

endinterface

// File: rtl/mem_responder_fifo.sv
// Power-of-two request FIFO with wrap-around pointers; push is ignored when full, pop when empty.
module mem_responder_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 40,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == PTR_W'(0) + (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they were written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Backing-memory responder: queues L2 requests, holds each for a fixed latency, answers in order.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 12
) (
    input  logic             i_clk,
    input  logic             i_reset,
    mem_responder_if.slave   bus_if,
    output logic [CNT_W-1:0] o_mem_reads,
    output logic [CNT_W-1:0] o_mem_writes,
    output logic [CNT_W-1:0] o_bad_ops,
    output logic             o_busy
);

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..255");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_responder: DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        op;
    } mem_req_t;

    localparam int unsigned REQ_W    = ADDR_W + 8;
    localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

    resp_state_t            r_state;
    resp_state_t            w_state_next;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_next;
    mem_req_t               r_hold;
    mem_req_t               w_hold_next;
    mem_req_t               w_req_in;
    mem_req_t               w_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_rsp_valid;
    logic                   w_hs;
    op_class_t              w_hold_class;
    logic [CNT_W-1:0]       r_mem_reads;
    logic [CNT_W-1:0]       r_mem_writes;
    logic [CNT_W-1:0]       r_bad_ops;

    assign w_req_in = {bus_if.req_addr, bus_if.req_op};
    assign w_push   = bus_if.req_valid && !w_full;

    mem_responder_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (w_req_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Ready reflects occupancy only, so a same-cycle pop never opens a full queue.
    assign bus_if.req_ready = !w_full;

    assign w_rsp_valid  = (r_state == StResp);
    assign w_hs         = w_rsp_valid && bus_if.rsp_ready;
    assign w_hold_class = classify_op(r_hold.op);

    assign bus_if.rsp_valid = w_rsp_valid;
    assign bus_if.rsp_addr  = r_hold.addr;
    assign bus_if.rsp_op    = r_hold.op;
    assign bus_if.rsp_err   = w_rsp_valid && (w_hold_class == OpBad);

    assign o_busy = (w_count != '0) || (r_state != StIdle);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hold_next  = r_hold;
        w_pop        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_hold_next  = w_head;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_state_next = StResp;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            StResp: begin
                // Back-to-back service: go straight to WAIT on the handshake edge.
                if (bus_if.rsp_ready) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_hold_next  = w_head;
                        w_cnt_next   = CNT_LOAD;
                        w_state_next = StWait;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_hold  <= w_hold_next;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem_reads  <= '0;
            r_mem_writes <= '0;
            r_bad_ops    <= '0;
        end else if (w_hs) begin
            unique case (w_hold_class)
                OpRead:  r_mem_reads  <= sat_inc(r_mem_reads);
                OpWrite: r_mem_writes <= sat_inc(r_mem_writes);
                default: r_bad_ops    <= sat_inc(r_bad_ops);
            endcase
        end
    end

    assign o_mem_reads  = r_mem_reads;
    assign o_mem_writes = r_mem_writes;
    assign o_bad_ops    = r_bad_ops;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised + directed bench for mem_responder against a transaction-level timing model.
module tb_mem_responder;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned LATENCY   = 4;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CNT_W     = 12;
    localparam int unsigned CNT_W_SAT = 2;
    localparam logic [7:0]  OP_R      = 8'h72;
    localparam logic [7:0]  OP_W      = 8'h77;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [7:0]  req_op    = '0;
    logic        rsp_ready = 1'b0;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(ADDR_W)) bus_a ();
    mem_responder_if #(.ADDR_W(ADDR_W)) bus_b ();

    assign bus_a.req_valid = req_valid;
    assign bus_a.req_addr  = req_addr;
    assign bus_a.req_op    = req_op;
    assign bus_a.rsp_ready = rsp_ready;
    assign bus_b.req_valid = req_valid;
    assign bus_b.req_addr  = req_addr;
    assign bus_b.req_op    = req_op;
    assign bus_b.rsp_ready = rsp_ready;

    logic [CNT_W-1:0]     reads_a, writes_a, bad_a;
    logic [CNT_W_SAT-1:0] reads_b, writes_b, bad_b;
    logic                 busy_a, busy_b;

    mem_responder #(
        .ADDR_W (ADDR_W), .LATENCY (LATENCY), .DEPTH (DEPTH), .CNT_W (CNT_W)
    ) dut_a (
        .i_clk        (clk),
        .i_reset      (reset),
        .bus_if       (bus_a),
        .o_mem_reads  (reads_a),
        .o_mem_writes (writes_a),
        .o_bad_ops    (bad_a),
        .o_busy       (busy_a)
    );

    mem_responder #(
        .ADDR_W (ADDR_W), .LATENCY (LATENCY), .DEPTH (DEPTH), .CNT_W (CNT_W_SAT)
    ) dut_b (
        .i_clk        (clk),
        .i_reset      (reset),
        .bus_if       (bus_b),
        .o_mem_reads  (reads_b),
        .o_mem_writes (writes_b),
        .o_bad_ops    (bad_b),
        .o_busy       (busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a waiting queue plus one request in service that becomes visible
    // LATENCY edges after the edge that took it from the queue.
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  op;
    } req_t;

    req_t   m_q[$];
    req_t   m_cur;
    bit     m_svc   = 0;
    bit     m_live  = 0;
    longint m_edge  = 0;
    longint m_rdy_at = 0;
    longint m_reads = 0, m_writes = 0, m_bad = 0;
    bit     m_was_valid, m_can_push;

    function automatic bit m_valid();
        return m_svc && (m_edge >= m_rdy_at);
    endfunction

    function automatic longint sat(input longint v, input int unsigned w);
        longint mx = (64'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_svc    = 0;
            m_reads  = 0;
            m_writes = 0;
            m_bad    = 0;
            m_live   = 1;
        end else if (m_live) begin
            m_was_valid = m_valid();
            m_can_push  = (m_q.size() < DEPTH);
            if (m_was_valid && rsp_ready) begin
                if (m_cur.op == OP_R) m_reads++;
                else if (m_cur.op == OP_W) m_writes++;
                else m_bad++;
                m_svc = 0;
            end
            if (!m_svc && m_q.size() > 0) begin
                m_cur    = m_q.pop_front();
                m_svc    = 1;
                m_rdy_at = m_edge + 1 + LATENCY;
            end
            if (req_valid && m_can_push) begin
                m_q.push_back('{addr: req_addr, op: req_op});
            end
        end
        m_edge++;
    end

    logic [31:0] rsp_log[$];
    bit          log_en = 0;

    always @(negedge clk) begin
        if (m_live) begin
            check("req_ready", bus_a.req_ready, m_q.size() < DEPTH);
            check("rsp_valid", bus_a.rsp_valid, m_valid());
            check("rsp_valid_b", bus_b.rsp_valid, m_valid());
            check("busy", busy_a, (m_q.size() > 0) || m_svc);
            if (m_valid()) begin
                check("rsp_addr", bus_a.rsp_addr, m_cur.addr);
                check("rsp_op", bus_a.rsp_op, m_cur.op);
                check("rsp_err", bus_a.rsp_err, !(m_cur.op == OP_R || m_cur.op == OP_W));
            end
            check("mem_reads", reads_a, sat(m_reads, CNT_W));
            check("mem_writes", writes_a, sat(m_writes, CNT_W));
            check("bad_ops", bad_a, sat(m_bad, CNT_W));
            check("mem_reads_sat", reads_b, sat(m_reads, CNT_W_SAT));
            check("mem_writes_sat", writes_b, sat(m_writes, CNT_W_SAT));
            check("bad_ops_sat", bad_b, sat(m_bad, CNT_W_SAT));
        end
        if (log_en && bus_a.rsp_valid && rsp_ready && !reset) begin
            rsp_log.push_back(bus_a.rsp_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid; an expired budget counts as a failure.
    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus_a.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check(name, bus_a.rsp_valid, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    logic [31:0] t2_addr[5];
    logic [7:0]  t2_op[5];
    logic [31:0] cap_addr;
    int          idx, edges, seen;
    bit          acc;

    initial begin
        t2_addr = '{32'h100, 32'h140, 32'h180, 32'h1C0, 32'h200};
        t2_op   = '{OP_R, OP_R, OP_W, OP_R, OP_W};

        // Reset values
        do_reset();
        check("rst_rsp_valid", bus_a.rsp_valid, 1'b0);
        check("rst_rsp_err", bus_a.rsp_err, 1'b0);
        check("rst_rsp_addr", bus_a.rsp_addr, 32'h0);
        check("rst_rsp_op", bus_a.rsp_op, 8'h0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_req_ready", bus_a.req_ready, 1'b1);
        check("rst_reads", reads_a, 0);

        // 1: single read, valid after edge 5, done after edge 6
        req_valid = 1'b1;
        req_addr  = 32'h0000_1A40;
        req_op    = OP_R;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t1_valid_timing", bus_a.rsp_valid, (k == 5));
        end
        check("t1_model_valid", m_valid(), 1'b1);
        check("t1_addr", bus_a.rsp_addr, 32'h0000_1A40);
        check("t1_err", bus_a.rsp_err, 1'b0);
        tick();
        check("t1_reads", reads_a, 1);
        check("t1_busy", busy_a, 1'b0);
        check("t1_valid_drop", bus_a.rsp_valid, 1'b0);

        // 2: fill the queue with responses blocked, then drain in order
        do_reset();
        idx   = 0;
        edges = 0;
        while (idx < 5 && edges < 20) begin
            req_valid = 1'b1;
            req_addr  = t2_addr[idx];
            req_op    = t2_op[idx];
            acc       = bus_a.req_ready;
            tick();
            edges++;
            if (acc) idx++;
        end
        req_valid = 1'b0;
        check("t2_accepted", idx, 5);
        check("t2_edges", edges, 5);
        check("t2_ready_low", bus_a.req_ready, 1'b0);
        rsp_log.delete();
        log_en    = 1;
        rsp_ready = 1'b1;
        repeat (40) tick();
        log_en = 0;
        check("t2_rsp_count", rsp_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rsp_log.size()) check("t2_order", rsp_log[i], t2_addr[i]);
        end
        check("t2_reads", reads_a, 3);
        check("t2_writes", writes_a, 2);
        check("t2_model_reads", m_reads, 3);

        // 3: held response stays stable under backpressure
        do_reset();
        req_valid = 1'b1;
        req_addr  = 32'h000B_EEF0;
        req_op    = OP_W;
        tick();
        req_valid = 1'b0;
        wait_valid("t3_valid_seen");
        cap_addr = bus_a.rsp_addr;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t3_hold_valid", bus_a.rsp_valid, 1'b1);
            check("t3_hold_addr", bus_a.rsp_addr, 32'h000B_EEF0);
            check("t3_hold_op", bus_a.rsp_op, OP_W);
            check("t3_hold_err", bus_a.rsp_err, 1'b0);
            check("t3_hold_writes", writes_a, 0);
        end
        check("t3_cap_addr", cap_addr, 32'h000B_EEF0);
        rsp_ready = 1'b1;
        tick();
        check("t3_writes", writes_a, 1);
        check("t3_valid_drop", bus_a.rsp_valid, 1'b0);

        // 4: illegal op
        do_reset();
        req_valid = 1'b1;
        req_addr  = 32'h0000_0777;
        req_op    = 8'h78;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_valid("t4_valid_seen");
        check("t4_err", bus_a.rsp_err, 1'b1);
        check("t4_op", bus_a.rsp_op, 8'h78);
        tick();
        check("t4_bad", bad_a, 1);
        check("t4_reads", reads_a, 0);
        check("t4_writes", writes_a, 0);

        // 5: reset while one is in WAIT and two are queued
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h3000 + 32'(i);
            req_op    = OP_R;
            tick();
        end
        req_valid = 1'b0;
        check("t5_busy_before", busy_a, 1'b1);
        check("t5_valid_before", bus_a.rsp_valid, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_valid", bus_a.rsp_valid, 1'b0);
        check("t5_busy", busy_a, 1'b0);
        check("t5_ready", bus_a.req_ready, 1'b1);
        check("t5_reads", reads_a, 0);
        rsp_ready = 1'b1;
        seen      = 0;
        repeat (20) begin
            tick();
            if (bus_a.rsp_valid) seen++;
        end
        check("t5_no_rsp", seen, 0);

        // 6: saturation on the narrow-counter instance
        do_reset();
        rsp_ready = 1'b1;
        idx   = 0;
        edges = 0;
        while (idx < 5 && edges < 50) begin
            req_valid = 1'b1;
            req_addr  = 32'h4000 + 32'(idx);
            req_op    = OP_R;
            acc       = bus_a.req_ready;
            tick();
            edges++;
            if (acc) idx++;
        end
        req_valid = 1'b0;
        repeat (30) tick();
        check("t6_reads_wide", reads_a, 5);
        check("t6_reads_sat", reads_b, 3);
        repeat (5) tick();
        check("t6_reads_sat_hold", reads_b, 3);

        // Random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int unsigned sel;
            sel       = $urandom_range(0, 9);
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = $urandom;
            req_op    = (sel < 5) ? OP_R : (sel < 9) ? OP_W : 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
